lemmings_dig_ctrl: RTL and testbench



---
 rtl/lemmings_dig_ctrl.sv | 106 ++++++++++
 tb/tb_lemmings_dig_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lemmings_dig_ctrl.sv
// Behaviour controller for one lemming: walk, fall, dig and splat.
// Moore machine; every action output is decoded from the registered state.
// fall_cnt records the length of the current or most recent fall, saturating.
module lemmings_dig_ctrl #(
  parameter int SPLAT_CYCLES = 20,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bump_left,
  input  logic             bump_right,
  input  logic             ground,
  input  logic             dig,
  output logic             walk_left,
  output logic             walk_right,
  output logic             aaah,
  output logic             digging,
  output logic             splat,
  output logic [CNT_W-1:0] fall_cnt
);

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SPLAT_LIM = CNT_W'(SPLAT_CYCLES);

  // state is kept as a named signal so checkers can bind to it directly
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_next;

  logic in_fall;
  logic next_fall;

  // State and fall counter registers; reset returns to walking left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WALK_L;
      fall_cnt <= '0;
    end else begin
      state    <= state_next;
      fall_cnt <= cnt_next;
    end
  end

  // Next-state selection; ground is checked first so a fall always wins
  always_comb begin
    state_next = state;
    case (state)
      WALK_L: begin
        if (!ground)        state_next = FALL_L;
        else if (dig)       state_next = DIG_L;
        else if (bump_left) state_next = WALK_R;
      end
      WALK_R: begin
        if (!ground)         state_next = FALL_R;
        else if (dig)        state_next = DIG_R;
        else if (bump_right) state_next = WALK_L;
      end
      DIG_L: begin
        if (!ground) state_next = FALL_L;
      end
      DIG_R: begin
        if (!ground) state_next = FALL_R;
      end
      FALL_L: begin
        if (ground) state_next = (fall_cnt > SPLAT_LIM) ? SPLAT : WALK_L;
      end
      FALL_R: begin
        if (ground) state_next = (fall_cnt > SPLAT_LIM) ? SPLAT : WALK_R;
      end
      SPLAT:   state_next = SPLAT;
      default: state_next = WALK_L;
    endcase
  end

  // Fall counter: load 1 on fall entry, count up while falling, else hold
  always_comb begin
    in_fall   = (state == FALL_L) || (state == FALL_R);
    next_fall = (state_next == FALL_L) || (state_next == FALL_R);
    cnt_next  = fall_cnt;
    if (next_fall && !in_fall) begin
      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (next_fall && in_fall && (fall_cnt != CNT_MAX)) begin
      cnt_next = fall_cnt + 1'b1;
    end
  end

  // One-hot action outputs decoded from state only
  always_comb begin
    walk_left  = (state == WALK_L);
    walk_right = (state == WALK_R);
    aaah       = (state == FALL_L) || (state == FALL_R);
    digging    = (state == DIG_L) || (state == DIG_R);
    splat      = (state == SPLAT);
  end

endmodule

// File: tb/tb_lemmings_dig_ctrl.sv
// Bench for lemmings_dig_ctrl: directed scenarios plus randomized play,
// checked every cycle against a behavioural model of the lemming.
module tb_lemmings_dig_ctrl;

  localparam int SPLAT_CYCLES = 20;
  localparam int CNT_W        = 5;
  localparam int CNT_SAT      = (1 << CNT_W) - 1;

  // model modes
  localparam int M_WALK = 0;
  localparam int M_FALL = 1;
  localparam int M_DIG  = 2;
  localparam int M_DEAD = 3;

  logic             clk;
  logic             rst_n;
  logic             bump_left;
  logic             bump_right;
  logic             ground;
  logic             dig;
  logic             walk_left;
  logic             walk_right;
  logic             aaah;
  logic             digging;
  logic             splat;
  logic [CNT_W-1:0] fall_cnt;

  int total;
  int bad;

  // behavioural model: direction (0 left, 1 right), activity, fall length
  int m_dir;
  int m_mode;
  int m_len;

  lemmings_dig_ctrl #(
    .SPLAT_CYCLES(SPLAT_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bump_left(bump_left),
    .bump_right(bump_right),
    .ground(ground),
    .dig(dig),
    .walk_left(walk_left),
    .walk_right(walk_right),
    .aaah(aaah),
    .digging(digging),
    .splat(splat),
    .fall_cnt(fall_cnt)
  );

  // clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int exp_cnt();
    return (m_len > CNT_SAT) ? CNT_SAT : m_len;
  endfunction

  // compare every DUT output with the model
  task automatic check_all(input string where);
    int ones;
    ones = int'(walk_left) + int'(walk_right) + int'(aaah) + int'(digging) + int'(splat);
    check({where, ".walk_left"},  32'(walk_left),  32'(m_mode == M_WALK && m_dir == 0));
    check({where, ".walk_right"}, 32'(walk_right), 32'(m_mode == M_WALK && m_dir == 1));
    check({where, ".aaah"},       32'(aaah),       32'(m_mode == M_FALL));
    check({where, ".digging"},    32'(digging),    32'(m_mode == M_DIG));
    check({where, ".splat"},      32'(splat),      32'(m_mode == M_DEAD));
    check({where, ".fall_cnt"},   32'(fall_cnt),   32'(exp_cnt()));
    check({where, ".onehot"},     32'(ones),       32'd1);
  endtask

  // model of one rising edge with the given sampled inputs
  task automatic model_step(input logic g, input logic d, input logic bl, input logic br);
    case (m_mode)
      M_WALK: begin
        if (!g) begin
          m_mode = M_FALL;
          m_len  = 1;
        end else if (d) begin
          m_mode = M_DIG;
        end else if ((m_dir == 0) ? bl : br) begin
          m_dir = 1 - m_dir;
        end
      end
      M_DIG: begin
        if (!g) begin
          m_mode = M_FALL;
          m_len  = 1;
        end
      end
      M_FALL: begin
        if (g) m_mode = (m_len > SPLAT_CYCLES) ? M_DEAD : M_WALK;
        else   m_len++;
      end
      default: ;
    endcase
  endtask

  // driver: called at a falling edge, applies inputs for one rising edge
  task automatic cycle(input logic g, input logic d, input logic bl, input logic br);
    ground     = g;
    dig        = d;
    bump_left  = bl;
    bump_right = br;
    @(posedge clk);
    model_step(g, d, bl, br);
    @(negedge clk);
    check_all("cyc");
  endtask

  // asynchronous reset, checked before the next rising edge
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_dir  = 0;
    m_mode = M_WALK;
    m_len  = 0;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b1;
    ground     = 1'b1;
    dig        = 1'b0;
    bump_left  = 1'b0;
    bump_right = 1'b0;
    m_dir      = 0;
    m_mode     = M_WALK;
    m_len      = 0;
    @(negedge clk);

    // reset and bumps
    do_reset();
    cycle(1, 0, 1, 0);
    check("bump_left_turns_right", 32'(walk_right), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 0);  // non-facing bump ignored while walking right
    check("nonfacing_bump_ignored", 32'(walk_right), 32'd1);

    // fall 20 cycles and survive
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    check("survive_cnt", 32'(fall_cnt), 32'd20);
    cycle(1, 1, 0, 0);  // dig not honoured on landing
    check("survive_walk_right", 32'(walk_right), 32'd1);

    // fall 21 cycles and splat, then stay dead
    do_reset();
    for (int i = 0; i < 21; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("splat_set", 32'(splat), 32'd1);
    for (int i = 0; i < 10; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("splat_sticky", 32'(splat), 32'd1);
    do_reset();

    // dig, ignore dig release and bumps, fall out and land
    cycle(1, 1, 0, 0);
    check("dig_start", 32'(digging), 32'd1);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 1);
    check("dig_holds", 32'(digging), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("dig_fall_land_cnt", 32'(fall_cnt), 32'd3);
    check("dig_fall_land_dir", 32'(walk_left), 32'd1);

    // priority: fall beats dig and bump
    cycle(1, 0, 1, 0);
    cycle(0, 1, 0, 1);
    check("prio_fall", 32'(aaah), 32'd1);
    cycle(1, 0, 0, 0);
    check("prio_land_right", 32'(walk_right), 32'd1);

    // saturation and reset mid-fall
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0);
    check("sat_cnt", 32'(fall_cnt), 32'(CNT_SAT));
    do_reset();

    // randomized play
    for (int n = 0; n < 1500; n++) begin
      if (m_mode == M_DEAD && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 15) == 0) begin
        int len;
        len = $urandom_range(1, 26);
        for (int k = 0; k < len; k++)
          cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cycle(1, 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
